// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the boot-time instruction memory loader.
package imem_loader_pkg;

    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned TIMEOUT_DEFAULT = 1023;

    typedef enum logic [2:0] {
        S_HDR,
        S_LO,
        S_HI,
        S_WR,
        S_DONE
    } state_t;

endpackage

// File: rtl/imem_loader_timeout.sv
// Idle-cycle counter: expire marks the TIMEOUT-th consecutive counted cycle.
module imem_loader_timeout
    import imem_loader_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_idle;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_idle <= '0;
        end else if (en) begin
            r_idle <= r_idle + 1'b1;
        end
    end

    assign expire = en && (r_idle == CW'(TIMEOUT - 1));

endmodule

// File: rtl/imem_loader.sv
// Assembles a counted byte frame into 16-bit words, writes them to IM from
// address 0 and holds the CPU in reset until the whole image is written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_cnt;
    logic [BYTE_W-1:0]   r_lo;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_cpu_rst;
    logic                r_done;
    logic                r_err;
    logic                w_xfer;
    logic                w_counting;
    logic                w_expire;
    logic [ADDR_W:0]     w_hdr_cnt;

    assign in_ready   = (r_state == S_HDR) || (r_state == S_LO) || (r_state == S_HI);
    assign w_xfer     = in_valid && in_ready;
    assign w_counting = (r_state == S_LO) || (r_state == S_HI);
    // A header byte of zero stands for a full 2^ADDR_W-word image.
    assign w_hdr_cnt  = (in_data == '0) ? ((ADDR_W + 1)'(1) << ADDR_W)
                                        : (ADDR_W + 1)'(in_data);

    imem_loader_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_xfer || !w_counting),
        .en     (w_counting && !w_xfer),
        .expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_HDR:   if (w_xfer) w_next = S_LO;
            S_LO:    if (w_xfer) w_next = S_HI;
                     else if (w_expire) w_next = S_HDR;
            S_HI:    if (w_xfer) w_next = S_WR;
                     else if (w_expire) w_next = S_HDR;
            S_WR:    w_next = (r_cnt == (ADDR_W + 1)'(1)) ? S_DONE : S_LO;
            S_DONE:  if (reload) w_next = S_HDR;
            default: w_next = S_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_cnt     <= '0;
            r_lo      <= '0;
            r_wdata   <= '0;
            r_cpu_rst <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_err     <= w_expire;
            r_cpu_rst <= (w_next != S_DONE);
            r_done    <= (w_next == S_DONE);
            unique case (r_state)
                S_HDR: if (w_xfer) begin
                    r_cnt  <= w_hdr_cnt;
                    r_addr <= '0;
                end
                S_LO: if (w_xfer) r_lo <= in_data;
                      else if (w_expire) r_addr <= '0;
                S_HI: if (w_xfer) r_wdata <= DATA_W'({in_data, r_lo});
                      else if (w_expire) r_addr <= '0;
                S_WR: begin
                    r_addr <= r_addr + 1'b1;
                    r_cnt  <= r_cnt - 1'b1;
                end
                S_DONE: if (reload) r_addr <= '0;
                default: ;
            endcase
        end
    end

    assign im_we    = (r_state == S_WR);
    assign im_addr  = r_addr;
    assign im_wdata = r_wdata;
    assign cpu_rst  = r_cpu_rst;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame table plus hand-written corner cases.
module tb_imem_loader;

    localparam int unsigned TO = 31;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        reload = 1'b0;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [15:0] im_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [23:0] exp_q[$];

    typedef struct {
        int          n;
        logic [15:0] seed;
        logic [15:0] step;
        bit          rnd;
        logic        exp_done;
    } frame_t;

    frame_t frames[4];

    always #5 clk = ~clk;

    imem_loader #(
        .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .reload   (reload),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_rst  (cpu_rst),
        .done     (done),
        .err      (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && im_we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", im_addr, im_wdata);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(im_addr), 32'(e[23:16]));
                check("wr_data", 32'(im_wdata), 32'(e[15:0]));
                check("wr_in_ready", 32'(in_ready), 32'd0);
            end
        end
    end

    // Called just after a falling edge; returns just after the falling edge that follows the transfer.
    task automatic send_byte(input logic [7:0] b);
        int unsigned k;
        k = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check("ready_wait", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load_frame(input int n, input logic [15:0] seed, input logic [15:0] step, input bit rnd);
        logic [15:0] w;
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            w = seed + 16'(i) * step;
            exp_q.push_back({8'(i), w});
            if (rnd) repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(w[7:0]);
            if (rnd) repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(w[15:8]);
        end
    endtask

    task automatic finish_frame(input logic exp_done);
        check("last_wr_we", 32'(im_we), 32'd1);
        check("last_wr_cpu_rst", 32'(cpu_rst), 32'd1);
        @(negedge clk);
        check("done", 32'(done), 32'(exp_done));
        check("cpu_rst_released", 32'(cpu_rst), 32'(!exp_done));
        check("done_in_ready", 32'(in_ready), 32'd0);
        check("sb_drained", exp_q.size(), 32'd0);
    endtask

    task automatic do_reload();
        repeat (3) @(negedge clk);
        check("done_held", 32'(done), 32'd1);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check("reload_cpu_rst", 32'(cpu_rst), 32'd1);
        check("reload_done", 32'(done), 32'd0);
        check("reload_in_ready", 32'(in_ready), 32'd1);
        check("reload_addr", 32'(im_addr), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_im_we"}, 32'(im_we), 32'd0);
        check({tag, "_im_addr"}, 32'(im_addr), 32'd0);
        check({tag, "_im_wdata"}, 32'(im_wdata), 32'd0);
        check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        frames[0] = '{n: 2,   seed: 16'h1234, step: 16'h4444, rnd: 1'b0, exp_done: 1'b1};
        frames[1] = '{n: 3,   seed: 16'hA5C3, step: 16'h0F0F, rnd: 1'b1, exp_done: 1'b1};
        frames[2] = '{n: 256, seed: 16'h0001, step: 16'h0103, rnd: 1'b0, exp_done: 1'b1};
        frames[3] = '{n: 1,   seed: 16'hBEEF, step: 16'h0000, rnd: 1'b1, exp_done: 1'b1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_values("reset");

        // Frame table; each later frame follows a reload and rewrites from address 0.
        foreach (frames[f]) begin
            load_frame(frames[f].n, frames[f].seed, frames[f].step, frames[f].rnd);
            finish_frame(frames[f].exp_done);
            do_reload();
        end

        // Idle timeout after lo byte of word 1.
        exp_q.push_back({8'h00, 16'hCAFE});
        send_byte(8'h02);
        send_byte(8'hFE);
        send_byte(8'hCA);
        send_byte(8'h11);
        repeat (TO - 1) @(negedge clk);
        check("to_err_early", 32'(err), 32'd0);
        check("to_ready_early", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("to_err", 32'(err), 32'd1);
        check("to_cpu_rst", 32'(cpu_rst), 32'd1);
        check("to_addr", 32'(im_addr), 32'd0);
        check("to_done", 32'(done), 32'd0);
        @(negedge clk);
        check("to_err_pulse", 32'(err), 32'd0);
        load_frame(2, 16'h0BAD, 16'h1111, 1'b0);
        finish_frame(1'b1);
        do_reload();

        // A transfer on the last idle cycle before expiry is accepted.
        exp_q.push_back({8'h00, 16'h7755});
        send_byte(8'h01);
        send_byte(8'h55);
        repeat (TO - 1) @(negedge clk);
        send_byte(8'h77);
        check("edge_err", 32'(err), 32'd0);
        finish_frame(1'b1);
        do_reload();

        // Reset asserted in HI mid-frame.
        exp_q.push_back({8'h00, 16'h3322});
        send_byte(8'h03);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("midrst");
        load_frame(3, 16'h9001, 16'h0202, 1'b1);
        finish_frame(1'b1);

        repeat (5) @(negedge clk);
        check("final_sb_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
